// File: rtl/calib_seq_pkg.sv
// -----------------------------------------------------------------------------
// calib_seq_pkg
// Shared definitions for the calibration run sequencer:
//   - default widths and timeout for calib_seq
//   - FSM state encoding
//   - helpers to replicate and majority-vote the (optionally triplicated)
//     FSM state register
// -----------------------------------------------------------------------------
package calib_seq_pkg;

    // Default configuration widths and CAL_GTRG wait timeout (clocks).
    localparam int CNT_W_DEF = 8;
    localparam int GAP_W_DEF = 16;
    localparam int TMO_DEF   = 255;

    // The timeout counter is always 8 bits wide; TMO must fit in it.
    localparam int TMO_W = 8;

    // FSM state encoding.
    localparam int ST_W = 3;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE   = 3'd0,
        ST_FIRE   = 3'd1,
        ST_WAIT   = 3'd2,
        ST_GAP    = 3'd3,
        ST_FINISH = 3'd4
    } state_t;

    // Three copies of the state, used as the FSM register.
    typedef logic [3*ST_W-1:0] state_rep_t;

    // Write the same next state into all three copies.
    function automatic state_rep_t rep3(input state_t s);
        return {s, s, s};
    endfunction

    // Bitwise 2-of-3 majority across the three copies.
    function automatic state_t vote3(input state_rep_t rep);
        logic [ST_W-1:0] a;
        logic [ST_W-1:0] b;
        logic [ST_W-1:0] c;
        a = rep[ST_W-1:0];
        b = rep[2*ST_W-1:ST_W];
        c = rep[3*ST_W-1:2*ST_W];
        return state_t'((a & b) | (a & c) | (b & c));
    endfunction

endpackage

// File: rtl/calib_seq_dncnt.sv
// -----------------------------------------------------------------------------
// calib_seq_dncnt
// Loadable down-counter with zero flag. Load has priority over decrement;
// decrementing stops at zero.
// Ports:
//   i_clk       clock, rising edge
//   i_rst_n     asynchronous active-low reset (count -> 0)
//   i_load      load i_load_val on the next edge
//   i_dec       decrement on the next edge (ignored while loading or at zero)
//   i_load_val  value to load
//   o_zero      count is zero
// -----------------------------------------------------------------------------
module calib_seq_dncnt #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic         i_dec,
    input  logic [W-1:0] i_load_val,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    // NOTE: sequential state is assigned with <= so every register samples
    // the pre-edge values of its neighbours, whatever the statement order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/calib_seq.sv
// -----------------------------------------------------------------------------
// calib_seq
// Calibration run sequencer (CLKCMS domain). On a rising edge of START while
// idle it issues NPULSE single-cycle strobes on CCBINJ (MODE=0) or CCBPLS
// (MODE=1). After each strobe it waits for the delayed CAL_GTRG return or a
// timeout of TMO+1 clocks, then waits max(GAP,1) clocks before the next
// strobe. ABORT ends an active run early.
// Ports:
//   i_clkcms       40 MHz CMS clock, rising edge
//   i_rst_n        asynchronous active-low reset
//   i_start        level; rising edge starts a run when idle
//   i_abort        level; ends an active run
//   i_mode         0 = inject (CCBINJ), 1 = pulse (CCBPLS)
//   i_npulse       strobes per run; 0 = empty run
//   i_gap          clocks from CAL_GTRG return to next strobe; 0 acts as 1
//   i_cal_gtrg     delayed calibration L1A return
//   o_ccbinj       single-cycle inject request
//   o_ccbpls       single-cycle pulse request
//   o_busy         high from run start through the DONE cycle
//   o_done         single-cycle end-of-run strobe
//   o_timeout_err  sticky timeout flag, cleared at next run start
//   o_ndone        strobes issued in the current/last run
// -----------------------------------------------------------------------------
module calib_seq
    import calib_seq_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int GAP_W = GAP_W_DEF,
    parameter int TMO   = TMO_DEF,
    parameter bit TMR   = 1'b0
) (
    input  logic             i_clkcms,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic             i_mode,
    input  logic [CNT_W-1:0] i_npulse,
    input  logic [GAP_W-1:0] i_gap,
    input  logic             i_cal_gtrg,
    output logic             o_ccbinj,
    output logic             o_ccbpls,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_timeout_err,
    output logic [CNT_W-1:0] o_ndone
);

    localparam logic [TMO_W-1:0] TMO_LD = TMO_W'(TMO);

    // FSM state (one or three copies) and its effective value.
    state_rep_t       r_state_rep;
    state_t           w_state;

    // START edge detect.
    logic             r_start_q;
    logic             w_start_le;

    // Run configuration latched at start.
    logic             r_mode;
    logic [CNT_W-1:0] r_npulse;
    logic [GAP_W-1:0] r_gap;

    // Registered outputs.
    logic             r_ccbinj;
    logic             r_ccbpls;
    logic             r_busy;
    logic             r_done;
    logic             r_tmo_err;
    logic [CNT_W-1:0] r_ndone;

    // Counter control and status.
    logic             w_tmo_zero;
    logic             w_gap_zero;
    logic             w_last;
    logic             w_wait_exit;
    logic [GAP_W-1:0] w_gap_ld_val;

    // With TMR the three copies are voted; otherwise only copy 0 is used and
    // the other two are left for synthesis to remove.
    assign w_state    = TMR ? vote3(r_state_rep) : state_t'(r_state_rep[ST_W-1:0]);

    assign w_start_le = i_start & ~r_start_q;

    // All requested strobes issued (NDONE already counts the current one).
    assign w_last     = (r_ndone == r_npulse);

    // WAIT ends on a return or on timeout, unless ABORT takes precedence.
    assign w_wait_exit = (w_state == ST_WAIT) && !i_abort && (i_cal_gtrg || w_tmo_zero);

    // The gap counter is loaded with max(GAP,1)-1 and GAP exits on zero, so
    // GAP lasts exactly max(GAP,1) cycles.
    assign w_gap_ld_val = (r_gap == '0) ? '0 : (r_gap - GAP_W'(1));

    // Timeout counter: loaded in FIRE so WAIT sees TMO..0, i.e. TMO+1 cycles.
    calib_seq_dncnt #(
        .W (TMO_W)
    ) u_tmo_cnt (
        .i_clk      (i_clkcms),
        .i_rst_n    (i_rst_n),
        .i_load     (w_state == ST_FIRE),
        .i_dec      (w_state == ST_WAIT),
        .i_load_val (TMO_LD),
        .o_zero     (w_tmo_zero)
    );

    // Gap counter: loaded on the WAIT -> GAP transition.
    calib_seq_dncnt #(
        .W (GAP_W)
    ) u_gap_cnt (
        .i_clk      (i_clkcms),
        .i_rst_n    (i_rst_n),
        .i_load     (w_wait_exit && !w_last),
        .i_dec      (w_state == ST_GAP),
        .i_load_val (w_gap_ld_val),
        .o_zero     (w_gap_zero)
    );

    always_ff @(posedge i_clkcms or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state_rep <= rep3(ST_IDLE);
            // Resetting to 1 means START held high across reset release is
            // not seen as a rising edge.
            r_start_q   <= 1'b1;
            r_mode      <= 1'b0;
            r_npulse    <= '0;
            r_gap       <= '0;
            r_ccbinj    <= 1'b0;
            r_ccbpls    <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_tmo_err   <= 1'b0;
            r_ndone     <= '0;
        end else begin
            r_start_q <= i_start;

            // Single-cycle outputs default low.
            r_ccbinj  <= 1'b0;
            r_ccbpls  <= 1'b0;
            r_done    <= 1'b0;

            // BUSY drops after the DONE cycle; a start accepted in that same
            // cycle (below) keeps it high.
            if (r_done) begin
                r_busy <= 1'b0;
            end

            case (w_state)
                ST_IDLE: begin
                    if (w_start_le) begin
                        r_mode    <= i_mode;
                        r_npulse  <= i_npulse;
                        r_gap     <= i_gap;
                        r_ndone   <= '0;
                        r_tmo_err <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state_rep <= (i_npulse != '0) ? rep3(ST_FIRE) : rep3(ST_FINISH);
                    end
                end

                ST_FIRE: begin
                    // The strobe is committed once FIRE is entered; ABORT only
                    // cuts the run short after it.
                    r_ndone  <= r_ndone + CNT_W'(1);
                    r_ccbinj <= ~r_mode;
                    r_ccbpls <= r_mode;
                    r_state_rep <= i_abort ? rep3(ST_FINISH) : rep3(ST_WAIT);
                end

                ST_WAIT: begin
                    if (i_abort) begin
                        r_state_rep <= rep3(ST_FINISH);
                    end else if (w_wait_exit) begin
                        // A return in the last timeout cycle is not an error.
                        if (!i_cal_gtrg) begin
                            r_tmo_err <= 1'b1;
                        end
                        r_state_rep <= w_last ? rep3(ST_FINISH) : rep3(ST_GAP);
                    end
                end

                ST_GAP: begin
                    if (i_abort) begin
                        r_state_rep <= rep3(ST_FINISH);
                    end else if (w_gap_zero) begin
                        r_state_rep <= rep3(ST_FIRE);
                    end
                end

                ST_FINISH: begin
                    r_done      <= 1'b1;
                    r_state_rep <= rep3(ST_IDLE);
                end

                default: begin
                    r_state_rep <= rep3(ST_IDLE);
                end
            endcase
        end
    end

    assign o_ccbinj      = r_ccbinj;
    assign o_ccbpls      = r_ccbpls;
    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_timeout_err = r_tmo_err;
    assign o_ndone       = r_ndone;

endmodule

// File: tb/tb_calib_seq.sv
// -----------------------------------------------------------------------------
// tb_calib_seq
// Self-checking bench for calib_seq. Each run record holds the configuration,
// the CAL_GTRG return latency, optional ABORT / extra START cycles and the
// expected outcome. Cycle 0 is the cycle in which START is raised; inputs are
// driven and outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_calib_seq;

    localparam int CNT_W = 8;
    localparam int GAP_W = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             i_start;
    logic             i_abort;
    logic             i_mode;
    logic [CNT_W-1:0] i_npulse;
    logic [GAP_W-1:0] i_gap;
    logic             i_cal_gtrg;
    logic             o_ccbinj;
    logic             o_ccbpls;
    logic             o_busy;
    logic             o_done;
    logic             o_timeout_err;
    logic [CNT_W-1:0] o_ndone;

    int n_checks = 0;
    int n_fails  = 0;

    calib_seq #(
        .CNT_W (CNT_W),
        .GAP_W (GAP_W),
        .TMO   (255),
        .TMR   (1'b0)
    ) dut (
        .i_clkcms      (clk),
        .i_rst_n       (rst_n),
        .i_start       (i_start),
        .i_abort       (i_abort),
        .i_mode        (i_mode),
        .i_npulse      (i_npulse),
        .i_gap         (i_gap),
        .i_cal_gtrg    (i_cal_gtrg),
        .o_ccbinj      (o_ccbinj),
        .o_ccbpls      (o_ccbpls),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_timeout_err (o_timeout_err),
        .o_ndone       (o_ndone)
    );

    always #5 clk = ~clk;

    // One run: configuration, stimulus timing and expected results.
    // lat        : cycles from a strobe to its CAL_GTRG (-1 = never returns)
    // abort_at   : cycle in which ABORT is high (-1 = none)
    // restart_at : cycle in which START is pulsed again (-1 = none)
    // exp_space  : expected strobe-to-strobe spacing
    // exp_tmo_dly: cycles from first strobe to TIMEOUT_ERR rising
    // exp_busy   : number of cycles with BUSY high
    typedef struct {
        logic             mode;
        logic [CNT_W-1:0] npulse;
        logic [GAP_W-1:0] gap;
        int               lat;
        int               abort_at;
        int               restart_at;
        int               exp_inj;
        int               exp_pls;
        int               exp_space;
        int               exp_ndone;
        int               exp_tmo;
        int               exp_tmo_dly;
        int               exp_busy;
    } vec_t;

    localparam int N_VEC = 11;
    vec_t vecs [N_VEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: actual %0d, required %0d", name, act, exp);
        end
    endtask

    // Drive one run and compare its outcome against the record.
    task automatic run_vec(input vec_t v, input string tag);
        int cyc;
        int inj_n;
        int pls_n;
        int done_n;
        int busy_n;
        int first_strobe;
        int last_strobe;
        int space_bad;
        int gtrg_due;
        int tmo_first;
        int ndone_at_done;
        int tmo_at_done;
        int idle_cnt;

        inj_n = 0; pls_n = 0; done_n = 0; busy_n = 0;
        first_strobe = -1; last_strobe = -1; space_bad = 0;
        gtrg_due = -1; tmo_first = -1; ndone_at_done = -1; tmo_at_done = -1;
        idle_cnt = 0;

        @(negedge clk);
        cyc        = 0;
        i_mode     = v.mode;
        i_npulse   = v.npulse;
        i_gap      = v.gap;
        i_start    = 1'b1;
        i_abort    = 1'b0;
        i_cal_gtrg = 1'b0;

        while (cyc < 2000 && idle_cnt < 6) begin
            @(negedge clk);
            cyc++;
            if (o_ccbinj) inj_n++;
            if (o_ccbpls) pls_n++;
            if (o_ccbinj || o_ccbpls) begin
                if (first_strobe < 0) begin
                    first_strobe = cyc;
                end else if ((cyc - last_strobe) != v.exp_space) begin
                    space_bad++;
                end
                last_strobe = cyc;
                if (v.lat >= 0) gtrg_due = cyc + v.lat;
            end
            if (o_busy) busy_n++;
            if (o_timeout_err && tmo_first < 0) tmo_first = cyc;
            if (o_done) begin
                done_n++;
                ndone_at_done = int'(o_ndone);
                tmo_at_done   = int'(o_timeout_err);
            end
            if (done_n > 0 && !o_busy) idle_cnt++;
            i_start    = (cyc == v.restart_at);
            i_abort    = (cyc == v.abort_at);
            i_cal_gtrg = (cyc == gtrg_due);
        end
        i_start    = 1'b0;
        i_abort    = 1'b0;
        i_cal_gtrg = 1'b0;

        check({tag, "_ended"}, idle_cnt, 6);
        if (v.exp_inj + v.exp_pls > 0) begin
            check({tag, "_first_strobe_cycle"}, first_strobe, 2);
        end
        check({tag, "_ccbinj_count"}, inj_n, v.exp_inj);
        check({tag, "_ccbpls_count"}, pls_n, v.exp_pls);
        check({tag, "_bad_spacings"}, space_bad, 0);
        check({tag, "_done_count"}, done_n, 1);
        check({tag, "_ndone_at_done"}, ndone_at_done, v.exp_ndone);
        check({tag, "_tmo_err_at_done"}, tmo_at_done, v.exp_tmo);
        if (v.exp_tmo != 0) begin
            check({tag, "_tmo_delay"}, tmo_first - first_strobe, v.exp_tmo_dly);
        end
        check({tag, "_busy_cycles"}, busy_n, v.exp_busy);
        check({tag, "_ndone_held"}, o_ndone, v.exp_ndone);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v5;
        int   act;

        //             mode  npulse  gap     lat  abort rst  inj  pls  space ndone tmo dly  busy
        vecs[0]  = '{1'b0, 8'd3,   16'd10, 5,   -1,   -1,  3,   0,   17,   3,    0,  0,   43};  // basic inject
        vecs[1]  = '{1'b1, 8'd1,   16'd10, -1,  -1,   -1,  0,   1,   0,    1,    1,  256, 259}; // no return
        vecs[2]  = '{1'b0, 8'd5,   16'd10, 5,   27,   -1,  2,   0,   17,   2,    0,  0,   29};  // abort in GAP
        vecs[3]  = '{1'b0, 8'd0,   16'd3,  2,   -1,   -1,  0,   0,   0,    0,    0,  0,   2};   // empty run
        vecs[4]  = '{1'b1, 8'd3,   16'd2,  4,   6,    4,   0,   1,   0,    1,    0,  0,   8};   // abort+gtrg, restart
        vecs[5]  = '{1'b0, 8'd2,   16'd0,  3,   -1,   -1,  2,   0,   6,    2,    0,  0,   13};  // GAP=0 acts as 1
        vecs[6]  = '{1'b1, 8'd3,   16'd1,  1,   -1,   -1,  0,   3,   4,    3,    0,  0,   13};  // short latency
        vecs[7]  = '{1'b0, 8'd2,   16'd4,  0,   -1,   -1,  2,   0,   6,    2,    0,  0,   10};  // return with strobe
        vecs[8]  = '{1'b0, 8'd1,   16'd5,  255, -1,   -1,  1,   0,   0,    1,    0,  0,   259}; // return in last WAIT cycle
        vecs[9]  = '{1'b1, 8'd2,   16'd3,  -1,  -1,   -1,  0,   2,   260,  2,    1,  256, 519}; // timeout then continue
        vecs[10] = '{1'b0, 8'd255, 16'd1,  0,   -1,   -1,  255, 0,   3,    255,  0,  0,   766}; // max NPULSE

        rst_n      = 1'b0;
        i_start    = 1'b0;
        i_abort    = 1'b0;
        i_mode     = 1'b0;
        i_npulse   = '0;
        i_gap      = '0;
        i_cal_gtrg = 1'b0;

        repeat (3) @(negedge clk);
        check("reset_outputs", {o_ccbinj, o_ccbpls, o_busy, o_done, o_timeout_err, o_ndone}, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_after_reset", {o_ccbinj, o_ccbpls, o_busy, o_done, o_timeout_err, o_ndone}, 0);

        for (int i = 0; i < N_VEC; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // ABORT while idle does nothing.
        act = 0;
        @(negedge clk);
        i_abort = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            act = act | int'(o_busy) | int'(o_done) | int'(o_ccbinj) | int'(o_ccbpls);
        end
        i_abort = 1'b0;
        check("abort_idle_ignored", act, 0);

        // Reset in WAIT while a strobe is high, START held through release.
        @(negedge clk);
        i_mode   = 1'b0;
        i_npulse = 8'd3;
        i_gap    = 16'd5;
        i_start  = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("t5_strobe_before_reset", o_ccbinj, 1);
        #2 rst_n = 1'b0;
        #1 check("t5_async_clear", {o_ccbinj, o_ccbpls, o_busy, o_done, o_timeout_err, o_ndone}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        act = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            act = act | int'(o_busy) | int'(o_done) | int'(o_ccbinj) | int'(o_ccbpls);
        end
        check("t5_no_run_while_start_held", act, 0);
        i_start = 1'b0;
        @(negedge clk);
        v5 = '{1'b0, 8'd1, 16'd2, 3, -1, -1, 1, 0, 0, 1, 0, 0, 7};
        run_vec(v5, "t5_after_toggle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
